ws2811_frame_sequencer: RTL
===========================

# ws2811_frame_sequencer

Frame-level controller for the WS2811 output path. On each frame trigger it walks `UNITS_NUMBER` pixels: it presents a color-memory address, waits out the memory's 1-cycle read latency, and issues a start pulse to the WS2811 transmitter. It then follows the transmitter's `busy` handshake until the pixel has gone out. After the last pixel it enforces the strip latch gap, then advances the animation shift. Pattern selection and pause come from single-cycle command pulses, for example decoded IR commands.

## Interface
- `UNITS_NUMBER`, 100: pixels per frame; must be ≥ 1.
- `PATTERN_COLORS_NUMBER`, 128: colors per pattern; must be a power of 2.
- `PATTERNS_NUMBER`, 4: number of patterns; must be a power of 2.
- `CLOCK_SPEED`, 50_000_000: clock frequency in Hz.
- `LATCH_US`, 60: latch gap after the last pixel, in µs.
- `clkIN` in 1: sole clock, rising edge.
- `nResetIN` in 1: asynchronous, active-low reset.
- `frameTriggerIN` in 1: 1-cycle pulse that requests a frame.
- `patternNextIN` in 1: pulse; next pattern.
- `patternPrevIN` in 1: pulse; previous pattern.
- `pauseToggleIN` in 1: pulse; toggles animation pause.
- `txBusyIN` in 1: transmitter busy.
- `addrOUT` out PW+CW: `{pattern, color}` address to the registered-output color ROM. PW = log2(`PATTERNS_NUMBER`); CW = log2(`PATTERN_COLORS_NUMBER`).
- `txStartOUT` out 1: 1-cycle start pulse to the transmitter.
- `frameBusyOUT` out 1: high from trigger acceptance until the latch gap ends.
- `frameDoneOUT` out 1: 1-cycle pulse at frame end.
- `overrunOUT` out 1: 1-cycle pulse when a trigger arrives while busy.

## Operation
- **Internal registers:**
  - `patSel` (PW bits): the requested pattern.
  - `patAct` (PW bits): the pattern used by the current frame.
  - `shift` (CW bits): animation offset.
  - `color` (CW bits): current pixel's color index.
  - `unit`: pixel counter, log2ceil(`UNITS_NUMBER`) bits.
  - `latchCnt`: latch-gap counter.
  - `paused`.
- **Pattern and pause commands:**
  - `patternNextIN` alone: `patSel` +1, wrapping mod `PATTERNS_NUMBER`.
  - `patternPrevIN` alone: `patSel` −1, wrapping.
  - Both in the same cycle: no change.
  - `pauseToggleIN` inverts `paused`.
  - All three are honored in every state.
- **States:** IDLE, FETCH, START, WAIT_ACK, WAIT_DONE, LATCH.
- **IDLE:**
  - On `frameTriggerIN`: `patAct` ← `patSel`, `color` ← `shift`, `unit` ← 0, `frameBusyOUT` ← 1, go to FETCH.
- **FETCH** (exactly 1 cycle): `addrOUT` = `{patAct, color}`, held stable; go to START.
- **START:** `txStartOUT` = 1 for this single cycle; go to WAIT_ACK.
- **WAIT_ACK:** wait for `txBusyIN` = 1, then go to WAIT_DONE.
- **WAIT_DONE:** wait for `txBusyIN` = 0.
  - If `unit` = `UNITS_NUMBER`−1: `latchCnt` ← 0, go to LATCH.
  - Otherwise: `unit`+1, `color`+1 (wrapping mod `PATTERN_COLORS_NUMBER`), go to FETCH.
- **LATCH:** count `LATCH_CYCLES` = `CLOCK_SPEED`/1_000_000 × `LATCH_US` cycles. On the final count:
  - `frameDoneOUT` pulses.
  - `frameBusyOUT` ← 0.
  - `shift` +1 (wrapping) unless `paused`.
  - Go to IDLE.
- **Trigger while busy:** `frameTriggerIN` in any state other than IDLE is dropped and `overrunOUT` pulses. The frame in progress is unaffected.
- **Pattern change mid-frame:** it does not affect the current frame (`patAct` is latched) and takes effect at the next trigger.
- **Reset, including mid-frame:**
  - State returns to IDLE.
  - `patSel`, `patAct`, `shift`, `color`, `unit`, `latchCnt` and `paused` are all 0.
  - All outputs are 0.
  - The transmitter is not aborted; the next frame's WAIT_ACK/WAIT_DONE tolerates a residual busy.

## Timing
- All outputs are registered.
- Reset values: `addrOUT` = 0, `txStartOUT` = 0, `frameBusyOUT` = 0, `frameDoneOUT` = 0, `overrunOUT` = 0.
- **Frame start:** with the trigger sampled at edge k:
  - `frameBusyOUT` and `addrOUT` are valid after edge k.
  - `txStartOUT` is high between edges k+1 and k+2.
  - ROM data is valid at edge k+2, where the transmitter samples both.
- **Inter-pixel gap:** from `txBusyIN` falling (sampled) to the next `txStartOUT` is 2 cycles (FETCH, START).
- **Frame end:** from the last `txBusyIN` falling to `frameDoneOUT` is `LATCH_CYCLES`+1 cycles.
- **Back-to-back frames:** a trigger in the same cycle as `frameDoneOUT` is an overrun. A trigger one cycle later is accepted.
- **`addrOUT` stability:** it changes only on the transition into FETCH.

## Test plan
- **Basic frame:** `UNITS_NUMBER`=3, `LATCH_US`=1, `CLOCK_SPEED`=50M, transmitter model with busy high for 10 cycles after start, one trigger. Required:
  - 3 `txStartOUT` pulses with `addrOUT` = 0, 1, 2.
  - `frameDoneOUT` 51 cycles after the last busy fall.
  - `shift` = 1.
- **Second frame:** trigger again after the basic frame. Required: addresses 1, 2, 3. After 128 frames, the address wraps to 0 within pattern 0.
- **Overrun:** trigger during WAIT_DONE. Required: `overrunOUT` is 1 for one cycle, frame completes unchanged, exactly 3 starts.
- **Pattern commands:**
  - `patternPrevIN` from reset: next frame uses address {3, 0}.
  - `patternNextIN` and `patternPrevIN` in the same cycle: no change.
  - `patternNextIN` mid-frame: only the next frame changes.
- **Pause:** `pauseToggleIN`, then two frames. Required: both frames start at the same color; toggling again resumes increments.
- **Reset mid-frame:** assert `nResetIN` during WAIT_ACK. Required:
  - All outputs are 0 immediately (asynchronously).
  - After release, a new trigger produces the address sequence starting at 0.

Source files
------------

// File: rtl/ws2811_frame_sequencer.sv
// ws2811_frame_sequencer
// Frame-level controller for the WS2811 output path. Each frame steps through
// the pixels, fetches each color from a registered-output ROM, and hands the
// color to the transmitter with a start pulse. After the last pixel it holds
// the strip latch gap and then advances the animation shift.
module ws2811_frame_sequencer #(
    parameter int UNITS_NUMBER          = 100,
    parameter int PATTERN_COLORS_NUMBER = 128,
    parameter int PATTERNS_NUMBER       = 4,
    parameter int CLOCK_SPEED           = 50_000_000,
    parameter int LATCH_US              = 60
) (
    input  logic clkIN,
    input  logic nResetIN,
    input  logic frameTriggerIN,
    input  logic patternNextIN,
    input  logic patternPrevIN,
    input  logic pauseToggleIN,
    input  logic txBusyIN,
    output logic [$clog2(PATTERNS_NUMBER)+$clog2(PATTERN_COLORS_NUMBER)-1:0] addrOUT,
    output logic txStartOUT,
    output logic frameBusyOUT,
    output logic frameDoneOUT,
    output logic overrunOUT
);

    localparam int PW           = $clog2(PATTERNS_NUMBER);
    localparam int CW           = $clog2(PATTERN_COLORS_NUMBER);
    localparam int UW           = (UNITS_NUMBER > 1) ? $clog2(UNITS_NUMBER) : 1;
    localparam int LATCH_CYCLES = (CLOCK_SPEED / 1_000_000) * LATCH_US;
    localparam int LW           = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [UW-1:0] LAST_UNIT  = UW'(UNITS_NUMBER - 1);
    localparam logic [LW-1:0] LAST_LATCH = LW'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        WAIT_ACK,
        WAIT_DONE,
        LATCH
    } state_t;

    state_t           state_q,    state_d;
    logic [PW-1:0]    patSel_q,   patSel_d;
    logic [PW-1:0]    patAct_q,   patAct_d;
    logic [CW-1:0]    shift_q,    shift_d;
    logic [CW-1:0]    color_q,    color_d;
    logic [UW-1:0]    unit_q,     unit_d;
    logic [LW-1:0]    latchCnt_q, latchCnt_d;
    logic             paused_q,   paused_d;
    logic [PW+CW-1:0] addr_q,     addr_d;
    logic             txStart_q,  txStart_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             overrun_q,  overrun_d;

    logic             ready;
    logic [CW-1:0]    colorNext;

    // The frame-done cycle already sits in IDLE, but a trigger landing on it is
    // still treated as part of the finishing frame and reported as an overrun.
    assign ready     = (state_q == IDLE) && !done_q;
    assign colorNext = color_q + 1'b1;

    assign addrOUT      = addr_q;
    assign txStartOUT   = txStart_q;
    assign frameBusyOUT = busy_q;
    assign frameDoneOUT = done_q;
    assign overrunOUT   = overrun_q;

    // Next-state and registered-output decode for the frame FSM and command inputs.
    always_comb begin
        state_d    = state_q;
        patSel_d   = patSel_q;
        patAct_d   = patAct_q;
        shift_d    = shift_q;
        color_d    = color_q;
        unit_d     = unit_q;
        latchCnt_d = latchCnt_q;
        paused_d   = paused_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        txStart_d  = 1'b0;
        done_d     = 1'b0;
        overrun_d  = 1'b0;

        if (patternNextIN && !patternPrevIN) begin
            patSel_d = patSel_q + 1'b1;
        end else if (patternPrevIN && !patternNextIN) begin
            patSel_d = patSel_q - 1'b1;
        end

        if (pauseToggleIN) begin
            paused_d = !paused_q;
        end

        if (frameTriggerIN && !ready) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (frameTriggerIN && ready) begin
                    patAct_d = patSel_q;
                    color_d  = shift_q;
                    unit_d   = '0;
                    addr_d   = {patSel_q, shift_q};
                    busy_d   = 1'b1;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                // ROM output settles during this cycle; start goes out next.
                txStart_d = 1'b1;
                state_d   = START;
            end
            START: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (txBusyIN) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!txBusyIN) begin
                    if (unit_q == LAST_UNIT) begin
                        latchCnt_d = '0;
                        state_d    = LATCH;
                    end else begin
                        unit_d  = unit_q + 1'b1;
                        color_d = colorNext;
                        addr_d  = {patAct_q, colorNext};
                        state_d = FETCH;
                    end
                end
            end
            LATCH: begin
                if (latchCnt_q == LAST_LATCH) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (!paused_q) begin
                        shift_d = shift_q + 1'b1;
                    end
                end else begin
                    latchCnt_d = latchCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything, including mid-frame.
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            state_q    <= IDLE;
            patSel_q   <= '0;
            patAct_q   <= '0;
            shift_q    <= '0;
            color_q    <= '0;
            unit_q     <= '0;
            latchCnt_q <= '0;
            paused_q   <= 1'b0;
            addr_q     <= '0;
            txStart_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            patSel_q   <= patSel_d;
            patAct_q   <= patAct_d;
            shift_q    <= shift_d;
            color_q    <= color_d;
            unit_q     <= unit_d;
            latchCnt_q <= latchCnt_d;
            paused_q   <= paused_d;
            addr_q     <= addr_d;
            txStart_q  <= txStart_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

endmodule
